// File: rtl/vc_evict_ctrl.sv
// Victim-cache eviction controller.
// Picks a victim entry on each allocation request. The first invalid entry
// wins; if every entry is valid, the round-robin pointer chooses. A dirty
// victim is written back before the allocation completes.
module vc_evict_ctrl #(
  parameter  int vc_size = 8,
  localparam int IW      = $clog2(vc_size)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_req,
  input  logic [vc_size-1:0] valid_in,
  input  logic [vc_size-1:0] dirty_in,
  input  logic               pmem_resp,
  output logic               meta_read,
  output logic               pmem_write,
  output logic [IW-1:0]      wb_idx,
  output logic               alloc_ready,
  output logic [IW-1:0]      alloc_idx,
  output logic [vc_size-1:0] valid_load,
  output logic [vc_size-1:0] dirty_load
);

  typedef enum logic [1:0] {IDLE, SELECT, WB, ALLOC} state_t;

  state_t       state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] victim_idx;
  logic          from_rr;     // victim came from rr_ptr (all entries valid)

  logic          free_found;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] victim;
  logic          need_wb;
  logic [vc_size-1:0] victim_oh;

  // Lowest-index invalid entry; scanning downward lets the lowest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = vc_size - 1; i >= 0; i--) begin
      if (!valid_in[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign victim  = free_found ? free_idx : rr_ptr;
  assign need_wb = valid_in[victim] & dirty_in[victim];

  // Main FSM; metadata is only trusted in SELECT because the arrays
  // return their data one cycle after meta_read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      victim_idx <= '0;
      from_rr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (alloc_req) state <= SELECT;
        end
        SELECT: begin
          victim_idx <= victim;
          from_rr    <= ~free_found;
          state      <= need_wb ? WB : ALLOC;
        end
        WB: begin
          if (pmem_resp) state <= ALLOC;
        end
        ALLOC: begin
          // Power-of-two size, so the increment wraps on its own.
          if (from_rr) rr_ptr <= rr_ptr + IW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign victim_oh   = {{(vc_size-1){1'b0}}, 1'b1} << victim_idx;

  assign meta_read   = (state == IDLE) && alloc_req;
  assign pmem_write  = (state == WB);
  assign alloc_ready = (state == ALLOC);
  assign wb_idx      = victim_idx;
  assign alloc_idx   = victim_idx;
  assign valid_load  = alloc_ready ? victim_oh : '0;
  assign dirty_load  = alloc_ready ? victim_oh : '0;

endmodule
